// File: rtl/uart_in.sv
// ---------------------------------------------------------------------------
// uart_in : 8N1 UART receiver with an ASCII hex line parser.
//
// Accepts serial frames on rx, assembles bytes, and parses text lines of
// exactly eight hex digits terminated by CR or LF into 32-bit words.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   rx         in   1   serial input, idles high
//   value      out 32   last accepted word, held until the next accept
//   value_good out  1   one-cycle pulse when value updates
//   error      out  1   one-cycle pulse when a line is rejected
//
// Build option: define UART_IN_LOWERCASE_EN to accept 'a'-'f' as hex digits.
// ---------------------------------------------------------------------------
module uart_in #(
  parameter int CLKS_PER_BIT = 435,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [31:0] value,
  output logic        value_good,
  output logic        error
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_sync;
  logic [CW-1:0]   tmr;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            stop_wait;
  logic            tick;
  logic            load_half, load_bit, shift_en, set_wait;
  logic            byte_done, frame_err;
  logic [4:0]      dec;

  logic [31:0]     acc;
  logic [3:0]      cnt;
  logic            bad;

  // Returns {is_digit, nibble} for one received byte.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if (b >= 8'h41 && b <= 8'h46)
      r = {1'b1, 4'(b[3:0] + 4'd9)};
`ifdef UART_IN_LOWERCASE_EN
    else if (b >= 8'h61 && b <= 8'h66)
      r = {1'b1, 4'(b[3:0] + 4'd9)};
`else
    else
      r = 5'd0;
`endif
    return r;
  endfunction

  // Input synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (tmr == '0);

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    set_wait  = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          state_nxt = S_START;
          load_half = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_sync) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            load_bit  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          load_bit = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // After a low stop bit, hold here until the line returns high so a
        // break is not decoded as a stream of zero bytes.
        if (stop_wait) begin
          if (rx_sync) state_nxt = S_IDLE;
        end else if (tick) begin
          if (rx_sync) begin
            byte_done = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_err = 1'b1;
            set_wait  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      bit_idx   <= 3'd0;
      stop_wait <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_half)
        tmr <= CW'(HALF_BIT - 1);
      else if (load_bit)
        tmr <= CW'(CLKS_PER_BIT - 1);
      else if (!tick)
        tmr <= tmr - 1'b1;
      if (state == S_DATA)
        bit_idx <= shift_en ? bit_idx + 3'd1 : bit_idx;
      else
        bit_idx <= 3'd0;
      stop_wait <= (state_nxt == S_STOP) && (stop_wait || set_wait);
    end
  end

  // Shift register holds data only; its contents are qualified by byte_done.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_sync, shreg[7:1]};
  end

  assign dec = hex_decode(shreg);

  // Line parser: registered outputs fire one clock after the stop sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= 32'd0;
      cnt        <= 4'd0;
      bad        <= 1'b0;
      value      <= 32'd0;
      value_good <= 1'b0;
      error      <= 1'b0;
    end else begin
      value_good <= 1'b0;
      error      <= 1'b0;
      if (frame_err) begin
        bad <= 1'b1;
      end else if (byte_done) begin
        if (shreg == 8'h0D || shreg == 8'h0A) begin
          if (cnt == 4'd8 && !bad) begin
            value      <= acc;
            value_good <= 1'b1;
          end else if (!(cnt == 4'd0 && !bad)) begin
            error <= 1'b1;
          end
          acc <= 32'd0;
          cnt <= 4'd0;
          bad <= 1'b0;
        end else if (dec[4]) begin
          acc <= {acc[27:0], dec[3:0]};
          if (cnt != 4'd9) cnt <= cnt + 4'd1;
        end else begin
          bad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_in.sv
module tb_uart_in;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] value;
  logic        value_good, error;

  logic        rx_slow = 1'b1;
  logic [31:0] slow_value;
  logic        slow_good, slow_err;

  int checks = 0;
  int failures = 0;
  int slow_events = 0;

  typedef struct {
    bit          err;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_good = 32'd0;

  always #5 clk = ~clk;

  uart_in #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .value(value), .value_good(value_good), .error(error)
  );

  // Default-rate instance used only for the long-glitch check.
  uart_in u_slow (
    .clk(clk), .reset_n(reset_n), .rx(rx_slow),
    .value(slow_value), .value_good(slow_good), .error(slow_err)
  );

  always @(negedge clk) begin
    if (reset_n && (slow_good || slow_err)) slow_events++;
  end

  // Monitor: pops the scoreboard whenever the DUT reports an event.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_good = 32'd0;
    end else if (value_good || error) begin
      checks++;
      if (value_good && error) begin
        failures++;
        $display("FAIL both_pulses: value_good=%0b error=%0b, required one-hot", value_good, error);
      end else if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: value_good=%0b error=%0b value=%h, required none",
                 value_good, error, value);
      end else begin
        e = q.pop_front();
        if (e.err) begin
          if (!error || value !== last_good) begin
            failures++;
            $display("FAIL error_event: error=%0b value=%h, required error=1 value=%h",
                     error, value, last_good);
          end
        end else begin
          if (!value_good || value !== e.val) begin
            failures++;
            $display("FAIL good_event: value_good=%0b value=%h, required value_good=1 value=%h",
                     value_good, value, e.val);
          end
          last_good = e.val;
        end
      end
    end
  end

  task automatic expect_good(input logic [31:0] v);
    exp_t e;
    e.err = 1'b0;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.err = 1'b1;
    e.val = 32'd0;
    q.push_back(e);
  endtask

  task automatic hold_rx(input logic level, input int clks);
    rx = level;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold_rx(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_rx(b[i], CPB);
    hold_rx(stop_bit, CPB);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_val("reset_value", value, 32'd0);
    check_val("reset_value_good", {31'd0, value_good}, 32'd0);
    check_val("reset_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    expect_good(32'h12345678);
    send_str("12345678\r\n");

    expect_good(32'h9ABCDEF0);
    expect_good(32'h00000104);
    send_str("9ABCDEF0\n");
    send_str("00000104\n");

    expect_err();
    expect_err();
    expect_err();
    send_str("123\r");
    send_str("1234G678\r");
    send_str("123456789\r");

    // Framing error extended into a break, then its terminator, then a clean line.
    send_byte(8'h00, 1'b0);
    hold_rx(1'b0, 3 * CPB);
    hold_rx(1'b1, 2 * CPB);
    expect_err();
    send_str("\n");
    expect_good(32'h55555555);
    send_str("55555555\n");

    // Glitches shorter than the start-bit validation point.
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 3 * CPB);
    rx_slow = 1'b0;
    repeat (100) @(negedge clk);
    rx_slow = 1'b1;
    repeat (1000) @(negedge clk);
    check_val("slow_glitch_events", 32'(slow_events), 32'd0);

    // Reset in the middle of a line discards the partial digits.
    send_str("1234");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midline_reset_value", value, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_good(32'h66666666);
    send_str("66666666\n");

`ifdef UART_IN_LOWERCASE_EN
    expect_good(32'hDEADBEEF);
`else
    expect_err();
`endif
    send_str("deadbeef\n");

    for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    check_val("scoreboard_drained", 32'(q.size()), 32'd0);
    check_val("final_value", value, last_good);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
